// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, watchdog limit, x0 index and control bundle.
// Pure types/constants; no latency or backpressure of its own.
package hazard_ctrl_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'd255;
    localparam logic [4:0] REG_X0     = 5'd0;

    typedef struct packed {
        logic no_op;
        logic pc_write;
        logic ifid_write;
        logic flush;
        logic freeze;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{no_op: 1'b0, pc_write: 1'b1, ifid_write: 1'b1,
                                       flush: 1'b0, freeze: 1'b0};
    localparam ctrl_t CTRL_FREEZE  = '{no_op: 1'b0, pc_write: 1'b0, ifid_write: 1'b0,
                                       flush: 1'b0, freeze: 1'b1};
    localparam ctrl_t CTRL_STALL   = '{no_op: 1'b1, pc_write: 1'b0, ifid_write: 1'b0,
                                       flush: 1'b0, freeze: 1'b0};
    localparam ctrl_t CTRL_FLUSH   = '{no_op: 1'b0, pc_write: 1'b1, ifid_write: 1'b1,
                                       flush: 1'b1, freeze: 1'b0};

    function automatic logic load_use(input logic       mem_read,
                                      input logic [4:0] ex_rd,
                                      input logic [4:0] id_rs1,
                                      input logic [4:0] id_rs2);
        return mem_read && (ex_rd != REG_X0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    endfunction

endpackage

// File: rtl/hazard_ctrl_perf_counter.sv
// Enable-increment event counter, wraps to zero on overflow.
// Latency: one cycle from enable to count; no backpressure.
module perf_counter
    import hazard_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: memory freeze > load-use stall > branch flush, plus stall/flush counters and a memory-wait watchdog.
// Latency: control outputs are combinational (same cycle); counters and watchdog update on the next edge; no backpressure.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  IDrs1_i,
    input  logic [4:0]  IDrs2_i,
    input  logic [4:0]  EXrd_i,
    input  logic        EXMemRead_i,
    input  logic        BranchTaken_i,
    input  logic        DmemReq_i,
    input  logic        DmemAck_i,
    output logic        No_op_o,
    output logic        PCWrite_o,
    output logic        IFIDWrite_o,
    output logic        Flush_o,
    output logic        Freeze_o,
    output logic [31:0] StallCnt_o,
    output logic [31:0] FlushCnt_o,
    output logic        Timeout_o
);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       timeout_q;
    logic       mem_busy;
    ctrl_t      ctrl;

    // In MEM_WAIT any cycle without ack keeps the back end frozen, regardless of DmemReq_i.
    always_comb begin
        mem_busy = (state == ST_MEM_WAIT) ? ~DmemAck_i : (DmemReq_i & ~DmemAck_i);
        ctrl     = CTRL_DEFAULT;
        if (!rst_i) begin
            if (mem_busy) begin
                ctrl = CTRL_FREEZE;
            end else if (load_use(EXMemRead_i, EXrd_i, IDrs1_i, IDrs2_i)) begin
                ctrl = CTRL_STALL;
            end else if (BranchTaken_i) begin
                ctrl = CTRL_FLUSH;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (DmemReq_i && !DmemAck_i) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (DmemAck_i) begin
                        state <= ST_RUN;
                    end else if (wait_cnt != WAIT_LIMIT) begin
                        // Saturate at the limit; the error flag stays sticky until reset.
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt + 8'd1 == WAIT_LIMIT) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    perf_counter #(.W(32)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (ctrl.freeze | ctrl.no_op),
        .cnt_o (StallCnt_o)
    );

    perf_counter #(.W(32)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (ctrl.flush),
        .cnt_o (FlushCnt_o)
    );

    assign No_op_o     = ctrl.no_op;
    assign PCWrite_o   = ctrl.pc_write;
    assign IFIDWrite_o = ctrl.ifid_write;
    assign Flush_o     = ctrl.flush;
    assign Freeze_o    = ctrl.freeze;
    assign Timeout_o   = timeout_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock, clk_i; reset rst_i is synchronous and active-high.
REQ-002 Ports SHALL be exactly:
- clk_i  in  1  rising-edge clock
- rst_i  in  1  synchronous active-high reset
- IDrs1_i  in  5  rs1 of instruction in ID
- IDrs2_i  in  5  rs2 of instruction in ID
- EXrd_i  in  5  rd of instruction in ID/EX
- EXMemRead_i  in  1  ID/EX instruction is a load
- BranchTaken_i  in  1  branch resolved taken in ID
- DmemReq_i  in  1  MEM stage has a data-memory access this cycle
- DmemAck_i  in  1  data memory completes the access this cycle
- No_op_o  out  1  to decoder No_op_i; forces bubble into ID/EX
- PCWrite_o  out  1  PC update enable
- IFIDWrite_o  out  1  IF/ID update enable
- Flush_o  out  1  clear IF/ID to NOP
- Freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB
- StallCnt_o  out  32  total stall cycles since reset
- FlushCnt_o  out  32  total flushes since reset
- Timeout_o  out  1  sticky memory-wait watchdog error

Function
REQ-003 FSM SHALL have two states: RUN and MEM_WAIT.
REQ-004 Load-use hazard SHALL be defined as EXMemRead_i & (EXrd_i != 0) & (EXrd_i == IDrs1_i | EXrd_i == IDrs2_i).
REQ-005 All control outputs SHALL be combinational from the current state and inputs, so they take effect in the same cycle.
REQ-006 Priority SHALL be: memory freeze > load-use stall > branch flush.
REQ-007 In RUN with DmemReq_i=1 and DmemAck_i=0:
- Freeze_o=1, PCWrite_o=0, IFIDWrite_o=0, No_op_o=0, Flush_o=0.
- Next state MEM_WAIT.
REQ-008 In RUN with DmemReq_i=1 and DmemAck_i=1 (single-cycle hit): no freeze; remain in RUN.
REQ-009 In MEM_WAIT:
- Freeze_o = ~DmemAck_i.
- PCWrite_o = IFIDWrite_o = DmemAck_i.
- No_op_o = 0; Flush_o = 0.
- Next state RUN on DmemAck_i=1.
REQ-010 In MEM_WAIT with DmemAck_i=1, load-use and branch logic SHALL apply as in RUN for that cycle.
REQ-011 Load-use stall, when not frozen:
- No_op_o=1, PCWrite_o=0, IFIDWrite_o=0, Flush_o=0 for exactly the cycles the condition holds.
- One cycle per load, because the load then moves out of ID/EX.
REQ-012 Branch flush, when not frozen and no load-use: BranchTaken_i=1 SHALL give Flush_o=1, with PCWrite_o=1 and IFIDWrite_o=1.
REQ-013 A branch coinciding with load-use or freeze SHALL be suppressed; ID re-resolves it later.
REQ-014 Default outputs (no hazard) SHALL be: PCWrite_o=1, IFIDWrite_o=1, all others 0.
REQ-015 StallCnt_o SHALL increment by 1 in every cycle where Freeze_o=1 or No_op_o=1, wrapping at 2^32-1 to 0.
REQ-016 FlushCnt_o SHALL increment by 1 in every cycle where Flush_o=1, wrapping at 2^32-1 to 0.
REQ-017 An 8-bit wait counter SHALL:
- clear on entry to MEM_WAIT;
- increment each MEM_WAIT cycle without ack;
- when it reaches 255, set Timeout_o=1 and keep it set until reset.
REQ-018 Timeout SHALL NOT alter freeze behaviour.

Reset
REQ-019 On rst_i=1 at a clock edge:
- state SHALL become RUN;
- StallCnt_o, FlushCnt_o, the wait counter and Timeout_o SHALL become 0.
REQ-020 During reset cycles, outputs SHALL show RUN-state default values.
REQ-021 Reset SHALL override MEM_WAIT mid-operation with no pending-access memory; counters SHALL not increment in a reset cycle.

Structure
REQ-022 FSM state encoding, WAIT_LIMIT (255), and the x0 register index constant SHALL live in the shared pipeline package.
REQ-023 One sub-module SHALL be used: perf_counter (32-bit enable-increment wrapping counter), instantiated twice.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Load-use: EXMemRead_i=1, EXrd_i=5, IDrs2_i=5 -> one cycle No_op_o=1, PCWrite_o=0, IFIDWrite_o=0; StallCnt_o +1.
- rd=x0: EXMemRead_i=1, EXrd_i=0, IDrs1_i=0 -> no stall; defaults held.
- Branch: BranchTaken_i=1, no hazard -> Flush_o=1 for one cycle; FlushCnt_o=1.
- Miss: DmemReq_i=1, ack after 4 cycles -> Freeze_o=1 for 4 cycles, RUN on ack, StallCnt_o=4; branch and load-use asserted meanwhile -> Flush_o=0, No_op_o=0.
- Watchdog and reset: DmemReq_i=1, no ack for 300 cycles -> Timeout_o=1 after 255 wait cycles; then rst_i one cycle -> state RUN, Timeout_o=0, both counters 0.
